// File: rtl/counter_sequencer_if.sv
// Command handshake bundle between a command source and the counter sequencer.
interface counter_sequencer_if #(
  parameter int NW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [NW-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_sequencer.sv
// Command-driven controller for an up/down counter: LOAD, UP N, DOWN N, HOLD N.
// Sole owner of the counter control pins; reports completion with a done pulse.
// result is captured at the end of the FINISH cycle, so it is valid from the
// cycle after done and holds until the next completion.
module counter_sequencer #(
  parameter int CW = 4,
  parameter int NW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_sequencer_if.slave   cmd,
  input  logic                 abort,
  output logic                 ctr_ld,
  output logic [CW-1:0]        ctr_ld_val,
  output logic                 ctr_dir,
  output logic                 ctr_en,
  input  logic [CW-1:0]        ctr_count,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        result
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FINISH} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  state_t        state_q, state_d;
  logic [NW-1:0] rem_q, rem_d;
  logic          ready_q, ready_d;
  logic          busy_d, done_d, ld_d, dir_d, en_d;
  logic [CW-1:0] ld_val_d, result_d;

  assign cmd.cmd_ready = ready_q;

  // State and registered outputs; async reset returns everything to idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      ctr_ld     <= 1'b0;
      ctr_ld_val <= '0;
      ctr_dir    <= 1'b1;
      ctr_en     <= 1'b0;
      result     <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      ready_q    <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
      ctr_ld     <= ld_d;
      ctr_ld_val <= ld_val_d;
      ctr_dir    <= dir_d;
      ctr_en     <= en_d;
      result     <= result_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // every pin comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ready_d  = ready_q;
    busy_d   = busy;
    done_d   = 1'b0;
    ld_d     = ctr_ld;
    ld_val_d = ctr_ld_val;
    dir_d    = ctr_dir;
    en_d     = ctr_en;
    result_d = result;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (cmd.cmd_op == OP_LOAD) begin
            state_d  = S_EXEC;
            rem_d    = NW'(1);
            ld_d     = 1'b1;
            ld_val_d = cmd.cmd_arg[CW-1:0];
          end else begin
            if (cmd.cmd_op == OP_UP || cmd.cmd_op == OP_DOWN)
              dir_d = (cmd.cmd_op == OP_UP);
            if (cmd.cmd_arg == '0) begin
              state_d = S_FINISH;
              done_d  = 1'b1;
            end else begin
              state_d = S_EXEC;
              rem_d   = cmd.cmd_arg;
              en_d    = (cmd.cmd_op != 2'b11);
            end
          end
        end
      end

      S_EXEC: begin
        rem_d = rem_q - NW'(1);
        if (abort) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          ld_d    = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else if (rem_q == NW'(1)) begin
          state_d = S_FINISH;
          en_d    = 1'b0;
          ld_d    = 1'b0;
          done_d  = 1'b1;
        end
      end

      S_FINISH: begin
        state_d  = S_IDLE;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        result_d = ctr_count;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        en_d    = 1'b0;
        ld_d    = 1'b0;
      end
    endcase
  end

endmodule
